// File: rtl/ripple_pkg.sv
// Shared types and helpers for the ripple counter reader.
package ripple_pkg;

  localparam int unsigned CNT_W_DEF = 4;
  localparam int unsigned EXT_W_DEF = 16;

  typedef enum logic [0:0] {
    StIdle,
    StHold
  } state_e;

  // Wrap-aware difference of two counter values, masked to the counter width.
  function automatic logic [31:0] mod_delta(input logic [31:0] cur, input logic [31:0] base,
                                            input int unsigned width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return (cur - base) & mask;
  endfunction

endpackage

// File: rtl/ripple_sync.sv
// Single-bit multi-stage synchronizer for an asynchronous input.
module ripple_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/ripple_count_reader.sv
// Samples a free-running ripple counter, accumulates wrap-aware deltas and offers snapshots.
// Define RIPPLE_COUNT_READER_DROP_CNT_EN to add the drop_cnt output for dropped sample requests.
module ripple_count_reader
  import ripple_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned EXT_W       = EXT_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] ripple_q,
  input  logic             clear,
  input  logic             sample_req,
  output logic             count_valid,
  input  logic             count_ready,
  output logic [EXT_W-1:0] count_out,
  output logic             overflow
`ifdef RIPPLE_COUNT_READER_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  logic [CNT_W-1:0] w_sync;
  logic [CNT_W-1:0] r_prev;
  logic [CNT_W-1:0] r_base;
  logic [CNT_W-1:0] w_base_d;
  logic [EXT_W-1:0] r_acc;
  logic [EXT_W-1:0] w_acc_d;
  logic             r_overflow;
  logic             w_overflow_d;
  logic [EXT_W-1:0] w_delta;
  logic [EXT_W:0]   w_sum;
  logic             w_stable;
  logic             w_fire;

  state_e           r_state;
  state_e           w_state_d;
  logic [EXT_W-1:0] r_count_out;
  logic [EXT_W-1:0] w_count_out_d;
  logic             r_count_valid;
  logic             w_count_valid_d;

  for (genvar g = 0; g < CNT_W; g++) begin : g_sync
    ripple_sync #(
      .STAGES(SYNC_STAGES)
    ) u_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .i_async(ripple_q[g]),
      .o_sync (w_sync[g])
    );
  end

  // A value only counts once it has been seen on two consecutive cycles.
  assign w_stable = (w_sync == r_prev);
  assign w_fire   = w_stable && (w_sync != r_base);
  assign w_delta  = EXT_W'(mod_delta(32'(w_sync), 32'(r_base), CNT_W));
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_delta};

  always_comb begin
    w_acc_d      = r_acc;
    w_base_d     = r_base;
    w_overflow_d = r_overflow;
    if (clear) begin
      w_acc_d      = '0;
      w_overflow_d = 1'b0;
      w_base_d     = r_prev;
    end else if (w_fire) begin
      w_acc_d  = w_sum[EXT_W-1:0];
      w_base_d = w_sync;
      if (w_sum[EXT_W]) begin
        w_overflow_d = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_count_out_d   = r_count_out;
    w_count_valid_d = r_count_valid;
    unique case (r_state)
      StIdle: begin
        if (sample_req) begin
          w_count_out_d   = r_acc;
          w_count_valid_d = 1'b1;
          w_state_d       = StHold;
        end
      end
      StHold: begin
        if (r_count_valid && count_ready) begin
          w_count_valid_d = 1'b0;
          w_state_d       = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev        <= '0;
      r_base        <= '0;
      r_acc         <= '0;
      r_overflow    <= 1'b0;
      r_state       <= StIdle;
      r_count_out   <= '0;
      r_count_valid <= 1'b0;
    end else begin
      r_prev        <= w_sync;
      r_base        <= w_base_d;
      r_acc         <= w_acc_d;
      r_overflow    <= w_overflow_d;
      r_state       <= w_state_d;
      r_count_out   <= w_count_out_d;
      r_count_valid <= w_count_valid_d;
    end
  end

  assign count_out   = r_count_out;
  assign count_valid = r_count_valid;
  assign overflow    = r_overflow;

`ifdef RIPPLE_COUNT_READER_DROP_CNT_EN
  logic       w_drop;
  logic [7:0] r_drop_cnt;

  // Any request seen while a snapshot is outstanding, including the accept cycle, is a drop.
  assign w_drop = (r_state == StHold) && sample_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop_cnt <= '0;
    end else if (clear) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  // Dropped requests are silently ignored in this build.
`endif

endmodule

// File: tb/tb_ripple_count_reader.sv
// Directed self-checking bench for ripple_count_reader.
module tb_ripple_count_reader;

  localparam int CNT_W = 4;
  localparam int EXT_W = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [CNT_W-1:0] ripple_q;
  logic             clear;
  logic             sample_req;
  logic             count_valid;
  logic             count_ready;
  logic [EXT_W-1:0] count_out;
  logic             overflow;
`ifdef RIPPLE_COUNT_READER_DROP_CNT_EN
  logic [7:0]       drop_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ripple_count_reader #(
    .CNT_W      (CNT_W),
    .EXT_W      (EXT_W),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ripple_q   (ripple_q),
    .clear      (clear),
    .sample_req (sample_req),
    .count_valid(count_valid),
    .count_ready(count_ready),
    .count_out  (count_out),
    .overflow   (overflow)
`ifdef RIPPLE_COUNT_READER_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rip(input logic [CNT_W-1:0] v, input int hold);
    ripple_q = v;
    tick(hold);
  endtask

  // Request, capture and accept one snapshot.
  task automatic take_snap(output logic [EXT_W-1:0] v, output logic vld);
    sample_req = 1'b1;
    tick(1);
    sample_req = 1'b0;
    vld = count_valid;
    v = count_out;
    count_ready = 1'b1;
    tick(1);
    count_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ripple_q = '0;
    clear = 1'b0;
    sample_req = 1'b0;
    count_ready = 1'b0;
    tick(3);
    n_tests++;
    if (count_valid !== 1'b0 || count_out !== 16'd0 || overflow !== 1'b0) begin
      $display("FAIL reset: valid=%b out=%0d ovf=%b, want 0/0/0", count_valid, count_out,
               overflow);
      n_fail++;
    end
`ifdef RIPPLE_COUNT_READER_DROP_CNT_EN
    n_tests++;
    if (drop_cnt !== 8'd0) begin
      $display("FAIL reset_drop: got %0d want 0", drop_cnt);
      n_fail++;
    end
`endif
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_steps();
    for (int v = 1; v <= 5; v++) set_rip(4'(v), 8);
    count_ready = 1'b1;
    tick(1);
    count_ready = 1'b0;
    n_tests++;
    if (count_valid !== 1'b0) begin
      $display("FAIL ready_idle: valid got %b want 0", count_valid);
      n_fail++;
    end
    sample_req = 1'b1;
    tick(1);
    sample_req = 1'b0;
    n_tests++;
    if (count_valid !== 1'b1 || count_out !== 16'd5) begin
      $display("FAIL steps_snap: valid=%b out=%0d want 1/5", count_valid, count_out);
      n_fail++;
    end
    tick(3);
    n_tests++;
    if (count_valid !== 1'b1 || count_out !== 16'd5) begin
      $display("FAIL steps_hold: valid=%b out=%0d want 1/5", count_valid, count_out);
      n_fail++;
    end
    count_ready = 1'b1;
    tick(1);
    count_ready = 1'b0;
    n_tests++;
    if (count_valid !== 1'b0) begin
      $display("FAIL steps_accept: valid got %b want 0", count_valid);
      n_fail++;
    end
  endtask

  task automatic test_wrap();
    logic [EXT_W-1:0] v;
    logic vld;
    set_rip(4'd14, 8);
    // Sample taken at the 4th edge after a step still sees the old total.
    ripple_q = 4'd15;
    tick(3);
    take_snap(v, vld);
    n_tests++;
    if (vld !== 1'b1 || v !== 16'd14) begin
      $display("FAIL latency_edge4: valid=%b out=%0d want 1/14", vld, v);
      n_fail++;
    end
    // Sample taken at the 5th edge after a step sees the new total.
    ripple_q = 4'd0;
    tick(4);
    take_snap(v, vld);
    n_tests++;
    if (vld !== 1'b1 || v !== 16'd16) begin
      $display("FAIL latency_edge5: valid=%b out=%0d want 1/16", vld, v);
      n_fail++;
    end
    set_rip(4'd1, 8);
    take_snap(v, vld);
    n_tests++;
    if (vld !== 1'b1 || v !== 16'd17) begin
      $display("FAIL wrap_total: valid=%b out=%0d want 1/17", vld, v);
      n_fail++;
    end
  endtask

  task automatic test_glitch();
    logic [EXT_W-1:0] v;
    logic vld;
    set_rip(4'd7, 8);
    set_rip(4'd4, 1);
    set_rip(4'd8, 8);
    take_snap(v, vld);
    n_tests++;
    if (vld !== 1'b1 || v !== 16'd24) begin
      $display("FAIL glitch: valid=%b out=%0d want 1/24", vld, v);
      n_fail++;
    end
  endtask

  task automatic test_overflow();
    logic [EXT_W-1:0] v;
    logic vld;
    logic [CNT_W-1:0] r;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(2);
    r = 4'd8;
    for (int i = 0; i < 4681; i++) begin
      r = r + 4'd14;
      set_rip(r, 3);
    end
    tick(4);
    n_tests++;
    if (overflow !== 1'b0) begin
      $display("FAIL preload_ovf: got %b want 0", overflow);
      n_fail++;
    end
    take_snap(v, vld);
    n_tests++;
    if (vld !== 1'b1 || v !== 16'd65534) begin
      $display("FAIL preload: valid=%b out=%0d want 1/65534", vld, v);
      n_fail++;
    end
    r = r + 4'd3;
    set_rip(r, 8);
    take_snap(v, vld);
    n_tests++;
    if (v !== 16'd1 || overflow !== 1'b1) begin
      $display("FAIL acc_wrap: out=%0d ovf=%b want 1/1", v, overflow);
      n_fail++;
    end
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    n_tests++;
    if (overflow !== 1'b0) begin
      $display("FAIL clear_ovf: got %b want 0", overflow);
      n_fail++;
    end
    take_snap(v, vld);
    n_tests++;
    if (vld !== 1'b1 || v !== 16'd0) begin
      $display("FAIL clear_acc: valid=%b out=%0d want 1/0", vld, v);
      n_fail++;
    end
  endtask

  task automatic test_hold_drop();
    set_rip(ripple_q + 4'd2, 8);
    ripple_q = ripple_q + 4'd1;
    sample_req = 1'b1;
    tick(1);
    n_tests++;
    if (count_valid !== 1'b1 || count_out !== 16'd2) begin
      $display("FAIL hold_first: valid=%b out=%0d want 1/2", count_valid, count_out);
      n_fail++;
    end
    tick(2);
    sample_req = 1'b0;
    tick(5);
    n_tests++;
    if (count_valid !== 1'b1 || count_out !== 16'd2) begin
      $display("FAIL hold_stable: valid=%b out=%0d want 1/2", count_valid, count_out);
      n_fail++;
    end
`ifdef RIPPLE_COUNT_READER_DROP_CNT_EN
    n_tests++;
    if (drop_cnt !== 8'd2) begin
      $display("FAIL drop_cnt: got %0d want 2", drop_cnt);
      n_fail++;
    end
`endif
    sample_req = 1'b1;
    count_ready = 1'b1;
    tick(1);
    sample_req = 1'b0;
    count_ready = 1'b0;
    tick(1);
    n_tests++;
    if (count_valid !== 1'b0) begin
      $display("FAIL accept_drop: valid got %b want 0", count_valid);
      n_fail++;
    end
`ifdef RIPPLE_COUNT_READER_DROP_CNT_EN
    n_tests++;
    if (drop_cnt !== 8'd3) begin
      $display("FAIL drop_accept: got %0d want 3", drop_cnt);
      n_fail++;
    end
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    n_tests++;
    if (drop_cnt !== 8'd0) begin
      $display("FAIL drop_clear: got %0d want 0", drop_cnt);
      n_fail++;
    end
`endif
  endtask

  task automatic test_clear_sample();
    logic [EXT_W-1:0] v;
    logic vld;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    set_rip(ripple_q + 4'd9, 8);
    sample_req = 1'b1;
    clear = 1'b1;
    tick(1);
    sample_req = 1'b0;
    clear = 1'b0;
    n_tests++;
    if (count_valid !== 1'b1 || count_out !== 16'd9) begin
      $display("FAIL clear_sample: valid=%b out=%0d want 1/9", count_valid, count_out);
      n_fail++;
    end
    count_ready = 1'b1;
    tick(1);
    count_ready = 1'b0;
    take_snap(v, vld);
    n_tests++;
    if (vld !== 1'b1 || v !== 16'd0) begin
      $display("FAIL after_clear: valid=%b out=%0d want 1/0", vld, v);
      n_fail++;
    end
  endtask

  task automatic test_reset_hold();
    sample_req = 1'b1;
    tick(1);
    sample_req = 1'b0;
    n_tests++;
    if (count_valid !== 1'b1) begin
      $display("FAIL pre_reset_hold: valid got %b want 1", count_valid);
      n_fail++;
    end
    #2;
    reset_n = 1'b0;
    ripple_q = '0;
    #1;
    n_tests++;
    if (count_valid !== 1'b0 || count_out !== 16'd0) begin
      $display("FAIL async_reset: valid=%b out=%0d want 0/0", count_valid, count_out);
      n_fail++;
    end
    tick(2);
    reset_n = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_steps();
    test_wrap();
    test_glitch();
    test_overflow();
    test_hold_drop();
    test_clear_sample();
    test_reset_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
